hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Issue-side companion to the EX-stage forwarding logic. It handles the hazards that
//  forwarding cannot resolve: load-use, RAW/WAW on results of the multi-cycle multiplier,
//  the multiplier structural hazard, and wrong-path instructions after a taken branch.
//  It keeps a registered per-register scoreboard and drives stall/bubble/flush controls
//  to PC, IF/ID and ID/EX.
// PARAMETERS
//  NREGS      32  architectural register count; scoreboard depth; x0 never tracked
//  RIDX_W      5  register index width, $clog2(NREGS)
//  CNT_W      32  width of the stall-cycle counter (only with HAZ_STALL_CNT_EN)
// PORTS
//  clk              in   1       core clock, rising edge
//  rst              in   1       asynchronous, active-high reset
//  id_valid         in   1       ID holds a real instruction
//  id_rs1/id_rs2    in   RIDX_W  ID source indices
//  id_uses_rs1/rs2  in   1       ID instruction reads that source
//  id_rd            in   RIDX_W  ID destination index
//  id_regwrite      in   1       ID instruction writes id_rd
//  id_is_mul        in   1       ID instruction goes to the multi-cycle multiplier
//  id_ex_memread    in   1       instruction in EX is a load
//  id_ex_rd         in   RIDX_W  EX destination index
//  ex_branch_taken  in   1       EX resolved a taken branch or jump this cycle
//  mul_done         in   1       multiplier result is written back this cycle (1-cycle pulse)
//  mul_done_rd      in   RIDX_W  destination of the completing multiply
//  stall_pc         out  1       hold PC
//  stall_if_id      out  1       hold IF/ID
//  bubble_id_ex     out  1       load a NOP into ID/EX
//  flush_if_id      out  1       invalidate IF/ID
//  flush_id_ex      out  1       invalidate ID/EX
//  mul_busy         out  1       one multiply is in flight (registered)
//  stall_cnt        out  CNT_W   stall-cycle count (only with HAZ_STALL_CNT_EN)
// BEHAVIOUR
//  State: busy[NREGS-1:1] and mul_busy, both registered. Reset clears all state.
//  All control outputs are forced to 0 while rst is high.
//  Hazard terms are combinational in the current cycle:
//  - lu     = id_valid & id_ex_memread & id_ex_rd!=0 &
//             (id_uses_rs1 & id_rs1==id_ex_rd | id_uses_rs2 & id_rs2==id_ex_rd)
//  - raw    = id_valid & (id_uses_rs1 & busy[id_rs1] | id_uses_rs2 & busy[id_rs2])
//             (uses the registered busy; no same-cycle bypass of mul_done)
//  - waw    = id_valid & id_regwrite & id_rd!=0 & busy[id_rd]
//  - struct = id_valid & id_is_mul & mul_busy & ~mul_done
//  - stall  = lu | raw | waw | struct
//  Output rules:
//  - ex_branch_taken: flush_if_id = flush_id_ex = 1; stall_pc, stall_if_id and
//    bubble_id_ex = 0. Flush overrides stall because the ID instruction is wrong-path.
//  - otherwise, stall: stall_pc = stall_if_id = bubble_id_ex = 1; flush_* = 0.
//  - otherwise all outputs are 0.
//  Issue event: id_valid & id_is_mul & ~stall & ~ex_branch_taken.
//  - Next cycle mul_busy = 1.
//  - Next cycle busy[id_rd] = 1 if id_regwrite and id_rd != 0.
//  Completion event: mul_done clears busy[mul_done_rd] and mul_busy next cycle.
//  - On a same-cycle issue, set wins on a matching index, and mul_busy stays 1.
//  - mul_done while mul_busy == 0 is ignored (no state change).
//  Stall latency:
//  - Load-use stall lasts exactly 1 cycle.
//  - A consumer of a multiply issues on the cycle after mul_done.
//  Reset mid-operation clears every busy bit; a pending multiply is forgotten.
// CONFIGURATION
//  HAZ_STALL_CNT_EN defined:
//  - stall_cnt increments, saturating at all-ones, on each cycle where
//    stall & ~ex_branch_taken.
//  - Reset value 0.
//  HAZ_STALL_CNT_EN undefined:
//  - The stall_cnt port and the counter are absent; all other behaviour is identical.
// TESTING
//  1 load x5 in EX, ID add x6,x5,x1 uses rs1 -> 1 cycle of stall+bubble, then all 0
//  2 same as 1 but id_ex_rd=0 -> no stall; x0 is never a hazard
//  3 mul x7 issues at T; mul_done rd=7 at T+3; ID reads x7 from T+1
//    -> stall T+1..T+3, issue at T+4
//  4 mul busy, second mul in ID; mul_done same cycle
//    -> no stall, mul_busy stays 1, new rd busy
//  5 ex_branch_taken with a load-use hazard present -> flush_if_id=flush_id_ex=1, stall_pc=0
//  6 rst pulse while mul_busy and busy[9] set -> mul_busy=0, busy cleared, outputs 0;
//    with HAZ_STALL_CNT_EN, check stall_cnt = count of stall cycles from tests 1-4

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Issue-side hazard unit: load-use, multiplier RAW/WAW/structural stalls and branch flushes.
// Optional saturating stall-cycle counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_stall_unit #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned RIDX_W = $clog2(NREGS),
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_mul,
    input  logic              id_ex_memread,
    input  logic [RIDX_W-1:0] id_ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mul_done,
    input  logic [RIDX_W-1:0] mul_done_rd,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              mul_busy
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             mul_busy_q, mul_busy_d;
    logic             lu, raw, waw, structural, stall, issue;

    always_comb begin
        lu = id_valid && id_ex_memread && (id_ex_rd != '0) &&
             ((id_uses_rs1 && (id_rs1 == id_ex_rd)) || (id_uses_rs2 && (id_rs2 == id_ex_rd)));
        // Registered busy only: a consumer waits until the cycle after mul_done.
        raw = id_valid && ((id_uses_rs1 && busy_q[id_rs1]) || (id_uses_rs2 && busy_q[id_rs2]));
        waw = id_valid && id_regwrite && (id_rd != '0) && busy_q[id_rd];
        structural = id_valid && id_is_mul && mul_busy_q && !mul_done;
        stall = lu || raw || waw || structural;
        issue = id_valid && id_is_mul && !stall && !ex_branch_taken;
    end

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (!rst) begin
            // The ID instruction is wrong-path on a taken branch, so flush beats stall.
            if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (stall) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d     = busy_q;
        mul_busy_d = mul_busy_q;
        if (mul_done && mul_busy_q) begin
            busy_d[mul_done_rd] = 1'b0;
            mul_busy_d          = 1'b0;
        end
        // Issue is applied after completion so a same-index set wins.
        if (issue) begin
            mul_busy_d = 1'b1;
            if (id_regwrite && (id_rd != '0)) begin
                busy_d[id_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            mul_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            mul_busy_q <= mul_busy_d;
        end
    end

    assign mul_busy = mul_busy_q;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall && !ex_branch_taken && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized traffic
// compared against a rule-level reference model (also covers HAZ_STALL_CNT_EN builds).
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_is_mul;
    logic [4:0] id_rs1, id_rs2, id_rd, id_ex_rd, mul_done_rd;
    logic       id_ex_memread, ex_branch_taken, mul_done;
    logic       stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, mul_busy;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_stall_unit dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_is_mul       (id_is_mul),
        .id_ex_memread   (id_ex_memread),
        .id_ex_rd        (id_ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mul_done        (mul_done),
        .mul_done_rd     (mul_done_rd),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .mul_busy        (mul_busy)
`ifdef HAZ_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: which registers await a multiply result.
    bit      m_busy[32];
    bit      m_mul_busy;
    int      m_mul_rd;
    longint  m_cnt;

    wire [4:0] ctrl = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_regwrite = 0; id_is_mul = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ex_rd = 0; mul_done_rd = 0;
        id_ex_memread = 0; ex_branch_taken = 0; mul_done = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic is_mul);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_regwrite = 1; id_is_mul = is_mul;
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_mul_busy = 0;
        m_mul_rd   = 0;
        m_cnt      = 0;
    endtask

    function automatic bit model_stall();
        bit lu, raw, waw, st;
        lu  = id_valid && id_ex_memread && id_ex_rd != 0 &&
              ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
        raw = id_valid && ((id_uses_rs1 && m_busy[id_rs1]) || (id_uses_rs2 && m_busy[id_rs2]));
        waw = id_valid && id_regwrite && id_rd != 0 && m_busy[id_rd];
        st  = id_valid && id_is_mul && m_mul_busy && !mul_done;
        return lu || raw || waw || st;
    endfunction

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        bit         stall, issue, nmb;
        bit         nb[32];
        logic [4:0] exp;
        #1;
        stall = model_stall();
        if (rst)                  exp = 5'b00000;
        else if (ex_branch_taken) exp = 5'b00011;
        else if (stall)           exp = 5'b11100;
        else                      exp = 5'b00000;
        check_eq("ctrl", 64'(ctrl), 64'(exp));
        issue = id_valid && id_is_mul && !stall && !ex_branch_taken;
        nb = m_busy;
        nmb = m_mul_busy;
        if (mul_done && m_mul_busy) begin
            nb[mul_done_rd] = 0;
            nmb = 0;
        end
        if (issue) begin
            nmb = 1;
            m_mul_rd = int'(id_rd);
            if (id_regwrite && id_rd != 0) nb[id_rd] = 1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (stall && !ex_branch_taken && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            m_busy = nb;
            m_mul_busy = nmb;
        end
        check_eq("mul_busy", 64'(mul_busy), 64'(m_mul_busy));
`ifdef HAZ_STALL_CNT_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1;
        id_ex_memread = 1; id_ex_rd = 5; set_id(5, 5, 6, 1);
        #1;
        check_eq("rst_ctrl", 64'(ctrl), 64'(0));
        check_eq("rst_mul_busy", 64'(mul_busy), 64'(0));
        @(negedge clk);
        cycle();
        rst = 0;
        clear_inputs();

        // 1: load-use on x5 stalls exactly one cycle
        id_ex_memread = 1; id_ex_rd = 5; set_id(5, 1, 6, 0); id_uses_rs2 = 1;
        #1 check_eq("t1_stall", 64'(ctrl), 64'(5'b11100));
        cycle();
        id_ex_memread = 0;
        #1 check_eq("t1_after", 64'(ctrl), 64'(0));
        cycle();

        // 2: load to x0 is never a hazard
        id_ex_memread = 1; id_ex_rd = 0; set_id(0, 0, 6, 0);
        #1 check_eq("t2_x0", 64'(ctrl), 64'(0));
        cycle();
        clear_inputs();

        // 3: consumer of x7 waits through mul_done, issues on the following cycle
        set_id(1, 2, 7, 1);
        #1 check_eq("t3_issue", 64'(ctrl), 64'(0));
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_id(7, 1, 8, 0);
            if (i == 2) begin mul_done = 1; mul_done_rd = 7; end
            #1 check_eq("t3_wait", 64'(ctrl), 64'(5'b11100));
            cycle();
        end
        mul_done = 0;
        #1 check_eq("t3_go", 64'(ctrl), 64'(0));
        cycle();

        // 4: back-to-back multiply issues in the completion cycle of the first
        set_id(1, 2, 3, 1);
        cycle();
        set_id(1, 2, 4, 1); mul_done = 1; mul_done_rd = 3;
        #1 check_eq("t4_nostall", 64'(ctrl), 64'(0));
        cycle();
        check_eq("t4_mul_busy", 64'(mul_busy), 64'(1));
        mul_done = 0; set_id(4, 1, 8, 0);
        #1 check_eq("t4_rd_busy", 64'(ctrl), 64'(5'b11100));
        cycle();
        clear_inputs(); mul_done = 1; mul_done_rd = 4;
        cycle();
        mul_done = 0;
`ifdef HAZ_STALL_CNT_EN
        check_eq("t4_cnt", 64'(stall_cnt), 64'(5));
`endif

        // 5: taken branch overrides a load-use stall
        id_ex_memread = 1; id_ex_rd = 5; set_id(5, 5, 6, 0); ex_branch_taken = 1;
        #1 check_eq("t5_flush", 64'(ctrl), 64'(5'b00011));
        cycle();
        clear_inputs();

        // 6: reset mid-multiply forgets busy[9]
        set_id(1, 2, 9, 1);
        cycle();
        rst = 1; set_id(9, 9, 10, 0);
        #1 check_eq("t6_rst_ctrl", 64'(ctrl), 64'(0));
        check_eq("t6_rst_mul_busy", 64'(mul_busy), 64'(0));
        cycle();
        rst = 0;
        #1 check_eq("t6_x9_free", 64'(ctrl), 64'(0));
`ifdef HAZ_STALL_CNT_EN
        check_eq("t6_cnt", 64'(stall_cnt), 64'(0));
`endif
        cycle();

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rst             = ($urandom_range(99) == 0);
            id_valid        = ($urandom_range(9) < 8);
            id_rs1          = 5'($urandom_range(3));
            id_rs2          = 5'($urandom_range(3));
            id_rd           = 5'($urandom_range(3));
            id_uses_rs1     = 1'($urandom_range(1));
            id_uses_rs2     = 1'($urandom_range(1));
            id_regwrite     = ($urandom_range(3) != 0);
            id_is_mul       = ($urandom_range(9) < 4);
            id_ex_memread   = ($urandom_range(3) == 0);
            id_ex_rd        = 5'($urandom_range(3));
            ex_branch_taken = ($urandom_range(9) == 0);
            if (m_mul_busy && $urandom_range(2) == 0) begin
                mul_done = 1; mul_done_rd = 5'(m_mul_rd);
            end else begin
                mul_done = ($urandom_range(19) == 0); mul_done_rd = 5'($urandom_range(3));
            end
            cycle();
        end
        rst = 0;
        clear_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
